// File: rtl/mask_modulator.sv
// M-level ASK modulator: maps B-bit symbols onto 2^B carrier amplitudes and
// streams SAMPLES_PER_SYM phase-continuous sine samples per symbol.
module mask_modulator #(
    parameter int DATA_W          = 16,
    parameter int BITS_PER_SYM    = 2,
    parameter int SAMPLES_PER_SYM = 64,
    parameter int AMP_STEP        = 10,
    parameter int PHASE_INC       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BITS_PER_SYM-1:0] sym_data,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    output logic [DATA_W-1:0]       out_sample,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    underrun
);

    localparam int CNT_W  = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam int PROD_W = DATA_W + BITS_PER_SYM + 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);
    localparam logic [5:0]       PH_STEP  = 6'(PHASE_INC);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [5:0]              phase_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [BITS_PER_SYM-1:0] level_r;
    logic                    xfer_s;
    logic                    last_s;
    logic [10:0]             sine_s;
    logic [DATA_W-1:0]       sample_s;

    // First quadrant of round(1000*sin(2*pi*k/64)), k = 0..16.
    function automatic logic [9:0] quarter_mag(input logic [4:0] a);
        case (a)
            5'd0:    quarter_mag = 10'd0;
            5'd1:    quarter_mag = 10'd98;
            5'd2:    quarter_mag = 10'd195;
            5'd3:    quarter_mag = 10'd290;
            5'd4:    quarter_mag = 10'd383;
            5'd5:    quarter_mag = 10'd471;
            5'd6:    quarter_mag = 10'd556;
            5'd7:    quarter_mag = 10'd634;
            5'd8:    quarter_mag = 10'd707;
            5'd9:    quarter_mag = 10'd773;
            5'd10:   quarter_mag = 10'd831;
            5'd11:   quarter_mag = 10'd882;
            5'd12:   quarter_mag = 10'd924;
            5'd13:   quarter_mag = 10'd957;
            5'd14:   quarter_mag = 10'd981;
            5'd15:   quarter_mag = 10'd995;
            5'd16:   quarter_mag = 10'd1000;
            default: quarter_mag = 10'd0;
        endcase
    endfunction

    // Full 64-entry offset sine built by mirroring the quadrant; range 0..2000.
    function automatic logic [10:0] sine_lut(input logic [5:0] idx);
        logic [4:0] m;
        logic [9:0] mag;
        m = idx[4:0];
        if (m > 5'd16) begin
            m = 5'd0 - m;
        end else begin
            m = idx[4:0];
        end
        mag = quarter_mag(m);
        if (idx[5]) begin
            sine_lut = 11'd1000 - {1'b0, mag};
        end else begin
            sine_lut = 11'd1000 + {1'b0, mag};
        end
    endfunction

    assign xfer_s = sym_valid && sym_ready;
    assign last_s = (cnt_r == LAST_CNT);
    assign sine_s = sine_lut(phase_r);
    assign sample_s = DATA_W'(PROD_W'(level_r) * PROD_W'(AMP_STEP) * PROD_W'(sine_s));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave RUN only when the last sample finds no successor.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s && !xfer_s) state_nxt_s = ST_IDLE;
                else                   state_nxt_s = ST_RUN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control outputs; sym_ready is held low while reset is asserted.
    always_comb begin
        sym_ready = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sym_ready = rst_n;
            end
            ST_RUN: begin
                busy      = 1'b1;
                sym_ready = rst_n && last_s;
            end
            default: begin
                sym_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Symbol datapath and registered sample output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r    <= 6'd0;
            cnt_r      <= '0;
            level_r    <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_sample <= '0;
                    out_valid  <= 1'b0;
                    underrun   <= 1'b0;
                    phase_r    <= 6'd0;
                    if (xfer_s) begin
                        level_r <= sym_data;
                        cnt_r   <= '0;
                    end else begin
                        level_r <= level_r;
                        cnt_r   <= cnt_r;
                    end
                end
                ST_RUN: begin
                    out_sample <= sample_s;
                    out_valid  <= 1'b1;
                    if (!last_s) begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                        phase_r  <= phase_r + PH_STEP;
                        underrun <= 1'b0;
                    end else if (xfer_s) begin
                        // Next symbol continues the carrier without a phase reset.
                        level_r  <= sym_data;
                        cnt_r    <= '0;
                        phase_r  <= phase_r + PH_STEP;
                        underrun <= 1'b0;
                    end else begin
                        cnt_r    <= '0;
                        phase_r  <= 6'd0;
                        underrun <= 1'b1;
                    end
                end
                default: begin
                    out_sample <= '0;
                    out_valid  <= 1'b0;
                    underrun   <= 1'b0;
                    phase_r    <= 6'd0;
                    cnt_r      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_modulator.sv
// Directed self-checking bench for mask_modulator: default, SPS=32 and
// PHASE_INC=4 instances share clock and reset.
module tb_mask_modulator;

    logic        clk;
    logic        rst_n;

    logic [1:0]  d0_data;
    logic        d0_valid, d0_ready, d0_ovalid, d0_busy, d0_under;
    logic [15:0] d0_sample;

    logic [1:0]  d1_data;
    logic        d1_valid, d1_ready, d1_ovalid, d1_busy, d1_under;
    logic [15:0] d1_sample;

    logic [1:0]  d2_data;
    logic        d2_valid, d2_ready, d2_ovalid, d2_busy, d2_under;
    logic [15:0] d2_sample;

    int n_checks = 0;
    int n_pass   = 0;

    mask_modulator u_dflt (
        .clk(clk), .rst_n(rst_n), .sym_data(d0_data), .sym_valid(d0_valid),
        .sym_ready(d0_ready), .out_sample(d0_sample), .out_valid(d0_ovalid),
        .busy(d0_busy), .underrun(d0_under)
    );

    mask_modulator #(.SAMPLES_PER_SYM(32)) u_b2b (
        .clk(clk), .rst_n(rst_n), .sym_data(d1_data), .sym_valid(d1_valid),
        .sym_ready(d1_ready), .out_sample(d1_sample), .out_valid(d1_ovalid),
        .busy(d1_busy), .underrun(d1_under)
    );

    mask_modulator #(.PHASE_INC(4)) u_pinc (
        .clk(clk), .rst_n(rst_n), .sym_data(d2_data), .sym_valid(d2_valid),
        .sym_ready(d2_ready), .out_sample(d2_sample), .out_valid(d2_ovalid),
        .busy(d2_busy), .underrun(d2_under)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d0_valid = 1'b0; d1_valid = 1'b0; d2_valid = 1'b0;
        d0_data = 2'd0;  d1_data = 2'd0;  d2_data = 2'd0;
        #2;
        n_checks++; if (d0_ovalid !== 1'b0 || d0_sample !== 16'd0) $display("FAIL reset_out valid=%b sample=%0d exp 0/0", d0_ovalid, d0_sample); else n_pass++;
        n_checks++; if (d0_busy !== 1'b0 || d0_under !== 1'b0) $display("FAIL reset_flags busy=%b underrun=%b exp 0/0", d0_busy, d0_under); else n_pass++;
        n_checks++; if (d0_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", d0_ready); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (d0_ready !== 1'b1 || d1_ready !== 1'b1) $display("FAIL idle_ready got %b/%b exp 1/1", d0_ready, d1_ready); else n_pass++;
    endtask

    task automatic test_sym3();
        int nvalid;
        logic [15:0] exp_v;
        d0_data = 2'd3; d0_valid = 1'b1;
        tick();
        d0_valid = 1'b0;
        n_checks++; if (d0_ovalid !== 1'b0 || d0_busy !== 1'b1 || d0_ready !== 1'b0)
            $display("FAIL sym3_accept valid=%b busy=%b ready=%b exp 0/1/0", d0_ovalid, d0_busy, d0_ready); else n_pass++;
        nvalid = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (d0_ovalid === 1'b1) nvalid++;
            if (n == 0 || n == 1 || n == 2 || n == 16 || n == 48) begin
                case (n)
                    0:       exp_v = 16'd30000;
                    1:       exp_v = 16'd32940;
                    2:       exp_v = 16'd35850;
                    16:      exp_v = 16'd60000;
                    default: exp_v = 16'd0;
                endcase
                n_checks++; if (d0_sample !== exp_v) $display("FAIL sym3_sample%0d got %0d exp %0d", n, d0_sample, exp_v); else n_pass++;
            end
            if (n == 62) begin
                n_checks++; if (d0_under !== 1'b0) $display("FAIL sym3_early_underrun got %b exp 0", d0_under); else n_pass++;
            end
            if (n == 63) begin
                n_checks++; if (d0_under !== 1'b1) $display("FAIL sym3_underrun got %b exp 1", d0_under); else n_pass++;
            end
        end
        n_checks++; if (nvalid != 64) $display("FAIL sym3_valid_count got %0d exp 64", nvalid); else n_pass++;
        tick();
        n_checks++; if (d0_ovalid !== 1'b0 || d0_under !== 1'b0 || d0_busy !== 1'b0)
            $display("FAIL sym3_end valid=%b underrun=%b busy=%b exp 0/0/0", d0_ovalid, d0_under, d0_busy); else n_pass++;
    endtask

    task automatic test_sym1_sym0();
        int nzero;
        logic [15:0] exp_v;
        d0_data = 2'd1; d0_valid = 1'b1;
        tick();
        d0_valid = 1'b0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (n < 3) begin
                case (n)
                    0:       exp_v = 16'd10000;
                    1:       exp_v = 16'd10980;
                    default: exp_v = 16'd11950;
                endcase
                n_checks++; if (d0_sample !== exp_v) $display("FAIL sym1_sample%0d got %0d exp %0d", n, d0_sample, exp_v); else n_pass++;
            end
        end
        tick();
        d0_data = 2'd0; d0_valid = 1'b1;
        tick();
        d0_valid = 1'b0;
        nzero = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (d0_ovalid === 1'b1 && d0_sample === 16'd0) nzero++;
        end
        n_checks++; if (nzero != 64) $display("FAIL sym0_zero_valid got %0d exp 64", nzero); else n_pass++;
        tick();
        n_checks++; if (d0_ovalid !== 1'b0) $display("FAIL sym0_end valid got %b exp 0", d0_ovalid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ready_hits, ready_at, gaps, unders;
        d1_data = 2'd1; d1_valid = 1'b1;
        tick();
        d1_data = 2'd2;
        ready_hits = 0; ready_at = -1; gaps = 0; unders = 0;
        for (int k = 0; k < 32; k++) begin
            if (d1_ready === 1'b1) begin ready_hits++; ready_at = k; end
            tick();
            if (d1_ovalid !== 1'b1) gaps++;
            if (d1_under !== 1'b0) unders++;
            if (k == 0) begin
                n_checks++; if (d1_sample !== 16'd10000) $display("FAIL b2b_first_s0 got %0d exp 10000", d1_sample); else n_pass++;
            end
            if (k == 31) begin
                n_checks++; if (d1_sample !== 16'd10980) $display("FAIL b2b_first_s31 got %0d exp 10980", d1_sample); else n_pass++;
            end
        end
        d1_valid = 1'b0;
        n_checks++; if (ready_hits != 1 || ready_at != 31) $display("FAIL b2b_ready hits=%0d at=%0d exp 1 at 31", ready_hits, ready_at); else n_pass++;
        for (int j = 0; j < 32; j++) begin
            tick();
            if (d1_ovalid !== 1'b1) gaps++;
            if (j == 0) begin
                n_checks++; if (d1_sample !== 16'd20000) $display("FAIL b2b_second_s0 got %0d exp 20000", d1_sample); else n_pass++;
            end
            if (j == 31) begin
                n_checks++; if (d1_sample !== 16'd18040) $display("FAIL b2b_second_s31 got %0d exp 18040", d1_sample); else n_pass++;
                n_checks++; if (d1_under !== 1'b1) $display("FAIL b2b_final_underrun got %b exp 1", d1_under); else n_pass++;
            end else if (d1_under !== 1'b0) begin
                unders++;
            end
        end
        n_checks++; if (gaps != 0 || unders != 0) $display("FAIL b2b_continuity gaps=%0d underruns=%0d exp 0/0", gaps, unders); else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        int pulses, valids;
        d1_data = 2'd1; d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (d1_under === 1'b1) pulses++;
        end
        valids = 0;
        for (int s = 0; s < 5; s++) begin
            tick();
            if (d1_under === 1'b1) pulses++;
            if (d1_ovalid !== 1'b0) valids++;
        end
        n_checks++; if (pulses != 1) $display("FAIL stall_underrun_pulses got %0d exp 1", pulses); else n_pass++;
        n_checks++; if (valids != 0 || d1_busy !== 1'b0) $display("FAIL stall_idle valid_cycles=%0d busy=%b exp 0/0", valids, d1_busy); else n_pass++;
        d1_data = 2'd3; d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        tick();
        n_checks++; if (d1_sample !== 16'd30000) $display("FAIL stall_restart_s0 got %0d exp 30000", d1_sample); else n_pass++;
        tick();
        n_checks++; if (d1_sample !== 16'd32940) $display("FAIL stall_restart_s1 got %0d exp 32940", d1_sample); else n_pass++;
        for (int k = 0; k < 31; k++) tick();
    endtask

    task automatic test_phase_inc();
        logic [15:0] exp_v;
        d2_data = 2'd2; d2_valid = 1'b1;
        tick();
        d2_valid = 1'b0;
        n_checks++; if (d2_busy !== 1'b1 || d2_ready !== 1'b0) $display("FAIL pinc_accept busy=%b ready=%b exp 1/0", d2_busy, d2_ready); else n_pass++;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (n == 0 || n == 1 || n == 2 || n == 4 || n == 12 || n == 15 || n == 16) begin
                case (n)
                    0:       exp_v = 16'd20000;
                    1:       exp_v = 16'd27660;
                    2:       exp_v = 16'd34140;
                    4:       exp_v = 16'd40000;
                    12:      exp_v = 16'd0;
                    15:      exp_v = 16'd12340;
                    default: exp_v = 16'd20000;
                endcase
                n_checks++; if (d2_sample !== exp_v) $display("FAIL pinc_sample%0d got %0d exp %0d", n, d2_sample, exp_v); else n_pass++;
            end
            if (n == 63) begin
                n_checks++; if (d2_under !== 1'b1) $display("FAIL pinc_underrun got %b exp 1", d2_under); else n_pass++;
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        d0_data = 2'd3; d0_valid = 1'b1;
        tick();
        d0_valid = 1'b0;
        for (int n = 0; n < 11; n++) tick();
        n_checks++; if (d0_ovalid !== 1'b1 || d0_sample !== 16'd54930) $display("FAIL rmid_sample10 valid=%b sample=%0d exp 1/54930", d0_ovalid, d0_sample); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (d0_ovalid !== 1'b0 || d0_sample !== 16'd0) $display("FAIL rmid_async_clear valid=%b sample=%0d exp 0/0", d0_ovalid, d0_sample); else n_pass++;
        n_checks++; if (d0_ready !== 1'b0 || d0_busy !== 1'b0) $display("FAIL rmid_ready_busy ready=%b busy=%b exp 0/0", d0_ready, d0_busy); else n_pass++;
        tick();
        n_checks++; if (d0_ready !== 1'b0 || d0_ovalid !== 1'b0) $display("FAIL rmid_held ready=%b valid=%b exp 0/0", d0_ready, d0_ovalid); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (d0_ready !== 1'b1) $display("FAIL rmid_ready_after got %b exp 1", d0_ready); else n_pass++;
        n_checks++; if (d0_ovalid !== 1'b0 || d0_sample !== 16'd0 || d0_busy !== 1'b0)
            $display("FAIL rmid_no_stale valid=%b sample=%0d busy=%b exp 0/0/0", d0_ovalid, d0_sample, d0_busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sym3();
        test_sym1_sym0();
        test_back_to_back();
        test_stall();
        test_phase_inc();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
